// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified instruction/data memory port arbiter.
// Access sizes, owner tags and arbiter FSM states.
package mem_port_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_lat_timer.sv
// Loadable down-counter timing the single outstanding memory access.
// o_done is a registered pulse exactly MEM_LAT cycles after the i_load cycle.
module mem_port_arbiter_lat_timer #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_done
);

  localparam logic [1:0] LOAD_VAL = 2'(MEM_LAT - 1);

  logic [1:0] r_cnt;
  logic       r_done;

  // A new load in the done cycle restarts the count for the back-to-back access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= LOAD_VAL;
      r_done <= (MEM_LAT == 1);
    end else begin
      r_done <= (r_cnt == 2'd1);
      if (r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
    end
  end

  assign o_done = r_done;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// with data priority bounded by a fetch starvation limit and one access in flight.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e     r_state, w_state_nxt;
  owner_e     r_owner, w_owner_nxt;
  logic [3:0] r_starve, w_starve_nxt;
  logic       r_we;

  logic w_done, w_rv, w_can_issue, w_if_wins, w_if_gnt, w_dm_gnt, w_issue;

  // Issue is legal when idle or in the cycle the outstanding access returns.
  assign w_rv        = w_done && !rst;
  assign w_can_issue = !rst && ((r_state == ST_IDLE) || w_done);
  assign w_if_wins   = if_req && (!dm_req || (r_starve == STARVE_LIM));
  assign w_if_gnt    = w_can_issue && w_if_wins;
  assign w_dm_gnt    = w_can_issue && dm_req && !w_if_wins;
  assign w_issue     = w_if_gnt || w_dm_gnt;

  mem_port_arbiter_lat_timer #(
    .MEM_LAT(MEM_LAT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_issue),
    .o_done(w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= OWN_NONE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_we <= w_dm_gnt && dm_we;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_starve_nxt = r_starve;
    if (w_issue) begin
      w_state_nxt = ST_WAIT;
      w_owner_nxt = w_if_gnt ? OWN_IF : OWN_DM;
    end else if (w_done) begin
      w_state_nxt = ST_IDLE;
      w_owner_nxt = OWN_NONE;
    end
    if (w_if_gnt || !if_req) begin
      w_starve_nxt = '0;
    end else if (w_dm_gnt && (r_starve != STARVE_LIM)) begin
      w_starve_nxt = r_starve + 4'd1;
    end
  end

  always_comb begin
    if_gnt    = w_if_gnt;
    dm_gnt    = w_dm_gnt;
    mem_en    = w_issue;
    mem_we    = w_dm_gnt && dm_we;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_if_gnt) begin
      mem_size = SIZE_W;
      mem_addr = if_addr;
    end else if (w_dm_gnt) begin
      mem_size = dm_size;
      mem_addr = dm_addr;
      if (dm_we) mem_wdata = dm_wdata;
    end
    if_rvalid = w_rv && (r_owner == OWN_IF);
    dm_rvalid = w_rv && (r_owner == OWN_DM);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = (dm_rvalid && !r_we) ? mem_rdata : '0;
  end

endmodule
